// File: rtl/frfcfs_request_scheduler.sv
// FR-FCFS DRAM request scheduler: age-ordered request queue, per-bank open-row/timer
// tracking, row-hit-first issue with a starvation cap on the oldest request.
module frfcfs_request_scheduler #(
  parameter int BANK_GROUPS        = 8,
  parameter int BANKS_PER_GROUP    = 8,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int DATA_W             = 64,
  parameter int QUEUE_SIZE         = 16,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int MAX_BYPASS         = 4,
  parameter int CLOSED_PAGE        = 0,
  localparam int BGW = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1,
  localparam int BKW = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1,
  localparam int CW  = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic                write_in,
  input  logic [BGW-1:0]      bank_group_in,
  input  logic [BKW-1:0]      bank_in,
  input  logic [ROW_BITS-1:0] row_in,
  input  logic [COL_BITS-1:0] col_in,
  input  logic [DATA_W-1:0]   val_in,
  input  logic                cmd_ready,
  output logic [2:0]          cmd_out,
  output logic                valid_out,
  output logic [BGW-1:0]      bank_group_out,
  output logic [BKW-1:0]      bank_out,
  output logic [ROW_BITS-1:0] row_out,
  output logic [COL_BITS-1:0] col_out,
  output logic [DATA_W-1:0]   val_out,
  output logic [CW-1:0]       queue_count
);
  localparam int BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BIW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int IW    = $clog2(QUEUE_SIZE);
  localparam int TMAX  = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BYW   = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;

  // Timers hold (latency-1): the bank is usable at the edge where the timer reads 0.
  localparam logic [TW-1:0]  ACT_T  = TW'((ACTIVATION_LATENCY > 0) ? ACTIVATION_LATENCY - 1 : 0);
  localparam logic [TW-1:0]  PRE_T  = TW'((PRECHARGE_LATENCY > 0) ? PRECHARGE_LATENCY - 1 : 0);
  localparam logic [BYW-1:0] BYP_MX = BYW'(MAX_BYPASS);
  localparam logic [CW-1:0]  QS_C   = CW'(QUEUE_SIZE);

  localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3,
                         CMD_PRE = 3'd4, CMD_RDA = 3'd5, CMD_WRA = 3'd6;

  typedef struct packed {
    logic                wr;
    logic [BGW-1:0]      bg;
    logic [BKW-1:0]      bk;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [DATA_W-1:0]   val;
  } req_t;

  function automatic logic [BIW-1:0] bidx(input req_t e);
    return BIW'(int'(e.bg) * BANKS_PER_GROUP + int'(e.bk));
  endfunction

  req_t                q_q [QUEUE_SIZE];
  req_t                q_d [QUEUE_SIZE];
  logic [CW-1:0]       count_q, count_d;
  logic [BYW-1:0]      byp_q, byp_d;
  logic [BANKS-1:0]    open_q, open_d;
  logic [ROW_BITS-1:0] orow_q [BANKS];
  logic [ROW_BITS-1:0] orow_d [BANKS];
  logic [TW-1:0]       tmr_q [BANKS];
  logic [TW-1:0]       tmr_d [BANKS];
  logic [2:0]          cmd_q, cmd_d;
  logic                vld_q, vld_d;
  req_t                out_q, out_d;

  logic [BIW-1:0]        ebank [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] hit;
  logic [IW-1:0]         sel_idx;
  logic [2:0]            sel_cmd;
  logic                  sel_col, found, shared, ap, issue, enq, deq;
  req_t                  sel_req, new_req;
  logic [BIW-1:0]        sel_bank;
  logic [CW-1:0]         wpos;

  assign ready_out = (count_q < QS_C);
  assign enq       = valid_in && ready_out;
  assign new_req   = '{wr: write_in, bg: bank_group_in, bk: bank_in, row: row_in, col: col_in, val: val_in};

  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      ebank[i] = bidx(q_q[i]);
      hit[i]   = (CW'(i) < count_q) && open_q[ebank[i]] &&
                 (orow_q[ebank[i]] == q_q[i].row) && (tmr_q[ebank[i]] == '0);
    end
  end

  always_comb begin
    sel_idx = '0;
    sel_cmd = CMD_NOP;
    sel_col = 1'b0;
    found   = 1'b0;
    if (byp_q != BYP_MX) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (hit[i] && !found) begin
          found   = 1'b1;
          sel_idx = IW'(i);
        end
      end
    end
    // No eligible hit (or forced): the oldest entry drives ACT/PRE or its own column command.
    if (found) begin
      sel_col = 1'b1;
    end else if (count_q != '0 && tmr_q[ebank[0]] == '0) begin
      if (!open_q[ebank[0]])                         sel_cmd = CMD_ACT;
      else if (orow_q[ebank[0]] == q_q[0].row)       sel_col = 1'b1;
      else                                           sel_cmd = CMD_PRE;
    end
    sel_req  = q_q[sel_idx];
    sel_bank = ebank[sel_idx];
    shared   = 1'b0;
    for (int j = 0; j < QUEUE_SIZE; j++) begin
      if (CW'(j) < count_q && IW'(j) != sel_idx && ebank[j] == sel_bank && q_q[j].row == sel_req.row)
        shared = 1'b1;
    end
    ap = (CLOSED_PAGE != 0) && !shared;
    if (sel_col) sel_cmd = sel_req.wr ? (ap ? CMD_WRA : CMD_WR) : (ap ? CMD_RDA : CMD_RD);
  end

  assign issue = cmd_ready && (sel_cmd != CMD_NOP);
  assign deq   = issue && sel_col;
  assign wpos  = count_q - CW'(deq);

  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++) q_d[i] = q_q[i];
    if (deq) begin
      for (int i = 0; i < QUEUE_SIZE - 1; i++)
        if (IW'(i) >= sel_idx) q_d[i] = q_q[i + 1];
    end
    if (enq) q_d[wpos[IW-1:0]] = new_req;
    count_d = count_q + CW'(enq) - CW'(deq);
    byp_d   = byp_q;
    if (deq) byp_d = (sel_idx == '0) ? '0 : byp_q + BYW'(1);
  end

  always_comb begin
    open_d = open_q;
    for (int b = 0; b < BANKS; b++) begin
      orow_d[b] = orow_q[b];
      tmr_d[b]  = (tmr_q[b] != '0) ? tmr_q[b] - TW'(1) : '0;
    end
    if (issue) begin
      case (sel_cmd)
        CMD_ACT: begin
          open_d[sel_bank] = 1'b1;
          orow_d[sel_bank] = sel_req.row;
          tmr_d[sel_bank]  = ACT_T;
        end
        CMD_PRE, CMD_RDA, CMD_WRA: begin
          open_d[sel_bank] = 1'b0;
          tmr_d[sel_bank]  = PRE_T;
        end
        default: ;
      endcase
    end
    cmd_d = issue ? sel_cmd : CMD_NOP;
    vld_d = issue;
    out_d = issue ? sel_req : out_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
      byp_q   <= '0;
      open_q  <= '0;
      cmd_q   <= CMD_NOP;
      vld_q   <= 1'b0;
      out_q   <= '0;
      for (int b = 0; b < BANKS; b++) begin
        orow_q[b] <= '0;
        tmr_q[b]  <= '0;
      end
    end else begin
      count_q <= count_d;
      byp_q   <= byp_d;
      open_q  <= open_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      for (int b = 0; b < BANKS; b++) begin
        orow_q[b] <= orow_d[b];
        tmr_q[b]  <= tmr_d[b];
      end
    end
  end

  // Payload storage needs no reset: occupancy is carried by count_q alone.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < QUEUE_SIZE; i++) q_q[i] <= q_d[i];
  end

  assign cmd_out        = cmd_q;
  assign valid_out      = vld_q;
  assign bank_group_out = out_q.bg;
  assign bank_out       = out_q.bk;
  assign row_out        = out_q.row;
  assign col_out        = out_q.col;
  assign val_out        = out_q.val;
  assign queue_count    = count_q;
endmodule

// File: doc/frfcfs_request_scheduler.md
Name: frfcfs_request_scheduler

Overview:
Parametrised DRAM request scheduler that succeeds the in-order request_scheduler. It sits between the cache-miss path and the DRAM command/timing controller. Requests are buffered in an age-ordered queue and issued first-ready / first-come-first-served: row hits go first, with a starvation cap on the oldest request. It tracks open rows and ACT/PRE timing per bank, and supports open-page or closed-page (auto-precharge) policy.

Parameters:
BANK_GROUPS, 8, number of bank groups
BANKS_PER_GROUP, 8, banks per group; BANKS = BANK_GROUPS*BANKS_PER_GROUP
ROW_BITS, 8, row address width
COL_BITS, 4, column address width
DATA_W, 64, write-data width
QUEUE_SIZE, 16, request queue depth (>=2)
ACTIVATION_LATENCY, 8, cycles from ACT to first column command on that bank
PRECHARGE_LATENCY, 5, cycles from PRE (or auto-precharge) to next ACT on that bank
MAX_BYPASS, 4, column commands allowed to overtake the oldest request before it is forced
CLOSED_PAGE, 0, 1 = column commands auto-precharge

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
valid_in  input  1  request valid
ready_out  output  1  queue can accept a request
write_in  input  1  1 = write, 0 = read
bank_group_in  input  clog2(BANK_GROUPS)  request bank group
bank_in  input  clog2(BANKS_PER_GROUP)  request bank
row_in  input  ROW_BITS  request row
col_in  input  COL_BITS  request column
val_in  input  DATA_W  write data
cmd_ready  input  1  controller accepts a command this cycle
cmd_out  output  3  0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 READ_AP, 6 WRITE_AP
valid_out  output  1  command valid (one-cycle pulse per command)
bank_group_out, bank_out, row_out, col_out, val_out  output  as inputs  command fields
queue_count  output  clog2(QUEUE_SIZE)+1  occupied entries

Behaviour:
- Reset (async): queue empty, all banks closed, all timers 0, bypass counter 0, cmd_out=NOP, valid_out=0, all field outputs 0. ready_out=1 once reset is released.
- ready_out = (queue_count < QUEUE_SIZE). The comparison uses the registered count; a same-edge dequeue does not free space for that edge.
- Enqueue at a rising edge when valid_in && ready_out. The entry becomes the youngest. The queue is kept age-ordered and compacts on removal. A new entry is not eligible for selection until the next cycle.
- Bank index = bank_group*BANKS_PER_GROUP + bank. Per bank: open flag, open row, busy timer.
- Selection (combinational, over valid entries, oldest first):
  - Forced mode when bypass counter == MAX_BYPASS: only the oldest entry is considered.
  - Otherwise, the oldest row-hit entry is chosen (bank open, same row, timer 0) → READ/WRITE.
  - If there is no row hit, the oldest entry is used:
    - bank timer != 0 → nothing issued;
    - bank closed → ACT on its bank/row;
    - bank open on a different row → PRE.
- Issue only at an edge where cmd_ready=1 and a command was selected. Outputs are registered, so valid_out=1 in the following cycle with all fields loaded. val_out is meaningful only for writes.
- At any edge with no issue: valid_out=0, cmd_out=NOP, field outputs hold.
- cmd_ready=0 stalls issue only; enqueue continues.
- ACT: bank open, row recorded. A column command on that bank may appear no earlier than ACTIVATION_LATENCY cycles after the ACT's valid_out cycle.
- PRE: bank closed. The next ACT on that bank appears no earlier than PRECHARGE_LATENCY cycles after the PRE.
- Column command: the entry is removed.
  - If CLOSED_PAGE=1 and no other queued entry hits the same bank/row, cmd_out=READ_AP/WRITE_AP, the bank closes, and the PRECHARGE_LATENCY timer starts.
  - Otherwise a plain READ/WRITE is issued and the bank stays open.
- Timers decrement by 1 per cycle and saturate at 0. Banks are fully independent.
- Bypass counter: +1 on each column command from a non-oldest entry. Cleared when the oldest entry is removed. ACT/PRE do not count.
- Simultaneous enqueue and dequeue: the count is unchanged and the new entry lands behind the compacted queue.
- Reset mid-operation discards all queued requests and bank state immediately.

Test Plan:
1. Empty queue, cmd_ready=1; write bg3 b2 row 0x55 col 0xA val A5A5A5A5A5A5A5A5 → ACT(3,2,0x55), then exactly ACTIVATION_LATENCY=8 cycles later WRITE col 0xA val A5A5…; queue_count returns to 0.
2. Enqueue reads bg2 b1: A row 0xF0 col 6, B row 0x0F col 8, C row 0xF0 col 1 → ACT 0xF0, RD col6, RD col1 (C overtakes B), PRE, ACT 0x0F ≥5 cycles after PRE, RD col8.
3. MAX_BYPASS=2: oldest entry row 0x0F on a bank open at row 0xF0, with 4 younger 0xF0 hits → two hits issue, then PRE/ACT/column for the oldest, then the remaining hits.
4. cmd_ready=0 while enqueuing 16 requests → valid_out stays 0, ready_out=0 at count 16, a 17th valid_in is ignored. Raising cmd_ready resumes issue and ready_out returns to 1 after the first dequeue.
5. CLOSED_PAGE=1, two reads to the same bank/row then one to another row → READ, READ_AP, and the next ACT no earlier than 5 cycles after READ_AP (no explicit PRE).
6. Assert rst_in between ACT and READ → outputs go to 0/NOP immediately, queue_count=0, and no READ follows after release.
